// File: rtl/mux_nx1_pipe.sv
// rtl/mux_nx1_pipe.sv - N-input W-bit selector with STAGES-deep registered output, valid, stall and flush; optional MUX_SEL_CHECK_EN adds sel_err
module mux_nx1_pipe #(
  parameter int W      = 32,
  parameter int N      = 4,
  parameter int SELW   = 2,
  parameter int STAGES = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N*W-1:0]      in_bus,
  input  logic [SELW-1:0]     select,
  input  logic                in_valid,
  input  logic                stall,
  input  logic                flush,
  output logic [W-1:0]        out,
  output logic                out_valid
`ifdef MUX_SEL_CHECK_EN
  ,
  output logic                sel_err
`endif
);

  // Reject configurations the select field cannot address or the pipe cannot build
  generate
    if (((1 << SELW) < N) || (STAGES < 1) || (STAGES > 4)) begin : g_bad_params
      $error("mux_nx1_pipe: illegal parameters (need 2**SELW >= N and 1 <= STAGES <= 4)");
    end
  endgenerate

  logic [W-1:0] sel_data;
  logic [W-1:0] data_q  [STAGES];
  logic         valid_q [STAGES];

  // Pick the addressed input; indices beyond N-1 yield zero rather than holding
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (select == SELW'(k)) begin
        sel_data = in_bus[k*W +: W];
      end
    end
  end

  // Pipeline registers: reset clears everything, flush drops valids only, stall holds all
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        data_q[i]  <= '0;
        valid_q[i] <= 1'b0;
      end
    end else if (flush) begin
      for (int i = 0; i < STAGES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (!stall) begin
      data_q[0]  <= sel_data;
      valid_q[0] <= in_valid;
      for (int i = 1; i < STAGES; i++) begin
        data_q[i]  <= data_q[i-1];
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  assign out       = data_q[STAGES-1];
  assign out_valid = valid_q[STAGES-1];

`ifdef MUX_SEL_CHECK_EN
  logic sel_ok;

  // Flag whether select addresses a real input
  always_comb begin
    sel_ok = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (select == SELW'(k)) begin
        sel_ok = 1'b1;
      end
    end
  end

  // Error flag tracks the latest capture edge only; flush leaves it, stall holds it
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_err <= 1'b0;
    end else if (!flush && !stall) begin
      sel_err <= in_valid && !sel_ok;
      if (in_valid && !sel_ok) begin
        $display("%0t mux_nx1_pipe: warning, select %0d out of range", $time, select);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// tb/tb_mux_nx1_pipe.sv - directed self-checking bench for mux_nx1_pipe across STAGES 1/2/3 and N=3
module tb_mux_nx1_pipe;

  localparam logic [31:0] VA = 32'hAAAA0000;
  localparam logic [31:0] VB = 32'hBBBB0001;
  localparam logic [31:0] VC = 32'hCCCC0002;
  localparam logic [31:0] VD = 32'hDDDD0003;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] in_bus;
  logic [1:0]   select;
  logic         in_valid;
  logic         stall;
  logic         flush;

  logic [31:0] out_s1, out_n3, out_s3, out_s2;
  logic        ov_s1, ov_n3, ov_s3, ov_s2;
`ifdef MUX_SEL_CHECK_EN
  logic        se_s1, se_n3, se_s3, se_s2;
`endif

  int checks_n = 0;
  int errors_n = 0;

  always #5 clk = ~clk;

  mux_nx1_pipe #(.W(32), .N(4), .SELW(2), .STAGES(1)) u_s1 (
    .clk(clk), .reset(reset), .in_bus(in_bus), .select(select), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out(out_s1), .out_valid(ov_s1)
`ifdef MUX_SEL_CHECK_EN
    , .sel_err(se_s1)
`endif
  );

  mux_nx1_pipe #(.W(32), .N(3), .SELW(2), .STAGES(1)) u_n3 (
    .clk(clk), .reset(reset), .in_bus(in_bus[95:0]), .select(select), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out(out_n3), .out_valid(ov_n3)
`ifdef MUX_SEL_CHECK_EN
    , .sel_err(se_n3)
`endif
  );

  mux_nx1_pipe #(.W(32), .N(4), .SELW(2), .STAGES(3)) u_s3 (
    .clk(clk), .reset(reset), .in_bus(in_bus), .select(select), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out(out_s3), .out_valid(ov_s3)
`ifdef MUX_SEL_CHECK_EN
    , .sel_err(se_s3)
`endif
  );

  mux_nx1_pipe #(.W(32), .N(4), .SELW(2), .STAGES(2)) u_s2 (
    .clk(clk), .reset(reset), .in_bus(in_bus), .select(select), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out(out_s2), .out_valid(ov_s2)
`ifdef MUX_SEL_CHECK_EN
    , .sel_err(se_s2)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_n++;
    if (got !== exp) begin
      errors_n++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then land 1 time unit after the capturing edge
  task automatic step(input logic [1:0] s, input logic v, input logic st, input logic fl, input logic rs);
    select   = s;
    in_valid = v;
    stall    = st;
    flush    = fl;
    reset    = rs;
    @(posedge clk);
    #1;
  endtask

  // STAGES=3 streaming: selects 0..3 then idle
  int          t3_sel [7] = '{0, 1, 2, 3, 0, 0, 0};
  logic        t3_vld [7] = '{1, 1, 1, 1, 0, 0, 0};
  logic [31:0] t3_out [7] = '{32'h0, 32'h0, VA, VB, VC, VD, VA};
  logic        t3_ov  [7] = '{0, 0, 1, 1, 1, 1, 0};

  // STAGES=3 with stall on cycles 3..4 while output is live
  int          t4_sel [9] = '{0, 1, 2, 3, 3, 0, 1, 1, 1};
  logic        t4_vld [9] = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
  logic        t4_stl [9] = '{0, 0, 0, 1, 1, 0, 0, 0, 0};
  logic [31:0] t4_out [9] = '{32'h0, 32'h0, VA, VA, VA, VB, VC, VA, VB};
  logic        t4_ov  [9] = '{0, 0, 1, 1, 1, 1, 1, 1, 0};

  initial begin
    in_bus = {VD, VC, VB, VA};
    step(2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("rst_s1_out", 64'(out_s1), 64'h0);
    check_eq("rst_s1_ov",  64'(ov_s1),  64'h0);
    check_eq("rst_s3_out", 64'(out_s3), 64'h0);
    check_eq("rst_s3_ov",  64'(ov_s3),  64'h0);
    check_eq("rst_s2_ov",  64'(ov_s2),  64'h0);
`ifdef MUX_SEL_CHECK_EN
    check_eq("rst_n3_err", 64'(se_n3),  64'h0);
`endif

    // Basic pick, one-cycle latency
    step(2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("pick2_s1_out", 64'(out_s1), 64'(VC));
    check_eq("pick2_s1_ov",  64'(ov_s1),  64'h1);
    check_eq("pick2_n3_out", 64'(out_n3), 64'(VC));

    // Out-of-range select on the N=3 instance yields zero
    step(2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("oor_n3_out", 64'(out_n3), 64'h0);
    check_eq("oor_n3_ov",  64'(ov_n3),  64'h1);
    check_eq("pick3_s1_out", 64'(out_s1), 64'(VD));
`ifdef MUX_SEL_CHECK_EN
    check_eq("oor_n3_err", 64'(se_n3), 64'h1);
    check_eq("oor_s1_err", 64'(se_s1), 64'h0);
`endif
    step(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("idle_n3_ov", 64'(ov_n3), 64'h0);
`ifdef MUX_SEL_CHECK_EN
    check_eq("clr_n3_err", 64'(se_n3), 64'h0);
`endif

    // Three-stage latency
    step(2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 7; c++) begin
      step(2'(t3_sel[c]), t3_vld[c], 1'b0, 1'b0, 1'b0);
      if (t3_ov[c]) check_eq($sformatf("lat3_out_c%0d", c), 64'(out_s3), 64'(t3_out[c]));
      check_eq($sformatf("lat3_ov_c%0d", c), 64'(ov_s3), 64'(t3_ov[c]));
    end
    check_eq("lat3_idle_data", 64'(out_s3), 64'(t3_out[6]));

    // Stall freezes output and drops stalled inputs
    step(2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 9; c++) begin
      step(2'(t4_sel[c]), t4_vld[c], t4_stl[c], 1'b0, 1'b0);
      check_eq($sformatf("stall_out_c%0d", c), 64'(out_s3), 64'(t4_out[c]));
      check_eq($sformatf("stall_ov_c%0d", c),  64'(ov_s3),  64'(t4_ov[c]));
    end

    // Flush with stall on STAGES=2: valids drop, data kept
    step(2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("fl_pre_out", 64'(out_s2), 64'(VA));
    check_eq("fl_pre_ov",  64'(ov_s2),  64'h1);
    step(2'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("fl_c1_out", 64'(out_s2), 64'(VA));
    check_eq("fl_c1_ov",  64'(ov_s2),  64'h0);
    step(2'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("fl_c2_out", 64'(out_s2), 64'(VA));
    check_eq("fl_c2_ov",  64'(ov_s2),  64'h0);
    step(2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("fl_c3_out", 64'(out_s2), 64'(VB));
    check_eq("fl_c3_ov",  64'(ov_s2),  64'h0);

    // Reset mid-stream discards in-flight entries
    step(2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef MUX_SEL_CHECK_EN
    check_eq("mid_pre_err", 64'(se_n3), 64'h1);
`endif
    step(2'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("mid_rst_s3_out", 64'(out_s3), 64'h0);
    check_eq("mid_rst_s3_ov",  64'(ov_s3),  64'h0);
    check_eq("mid_rst_s1_out", 64'(out_s1), 64'h0);
    check_eq("mid_rst_s1_ov",  64'(ov_s1),  64'h0);
`ifdef MUX_SEL_CHECK_EN
    check_eq("mid_rst_err", 64'(se_n3), 64'h0);
`endif
    step(2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("post_s1_out", 64'(out_s1), 64'(VD));
    check_eq("post_s1_ov",  64'(ov_s1),  64'h1);
    check_eq("post_s3_ov1", 64'(ov_s3),  64'h0);
    step(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("post_s3_ov2", 64'(ov_s3),  64'h0);
    step(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("post_s3_out", 64'(out_s3), 64'(VD));
    check_eq("post_s3_ov3", 64'(ov_s3),  64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks_n, errors_n);
    $finish;
  end

endmodule

// File: doc/mux_nx1_pipe.md
Name: mux_nx1_pipe

Overview:
- Parametrised N-input, W-bit selector with a configurable-depth registered output pipeline, a valid flag, stall and flush.
- Successor to the fixed-width 2/3/4-input combinational datapath selectors.
- Used where a selection must be aligned to a pipeline boundary, e.g. forwarding, writeback and PC-source selection with hazard stall and branch flush.
- Only bare combinational selection remains in the existing fixed muxes.

Parameters:
- W, 32, data width in bits (1..64).
- N, 4, number of data inputs (2..16).
- SELW, 2, select width; must satisfy 2^SELW >= N.
- STAGES, 1, number of pipeline register stages between select and output (1..4).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_bus  input  N*W  flattened data inputs; input k occupies bits [k*W+W-1 : k*W].
- select  input  SELW  index of the input to pass.
- in_valid  input  1  qualifies in_bus/select this cycle.
- stall  input  1  freezes all pipeline stages.
- flush  input  1  invalidates all stages.
- out  output  W  selected data from the final stage.
- out_valid  output  1  final-stage valid.
- sel_err  output  1  present only with MUX_SEL_CHECK_EN (see Optional Feature).

Behaviour:
- Combinational pick: sel_data = input[select] when select < N; sel_data = 0 when select >= N. No latch, no hold of the previous value.
- Pipeline: STAGES register stages, each holding {data[W], valid}. Stage 0 captures {sel_data, in_valid}; stage i captures stage i-1. out and out_valid come from stage STAGES-1.
- Latency: exactly STAGES cycles from the sampling edge to out when not stalled.
- Priority per clock edge: reset > flush > stall > normal advance.
- reset=1: every stage data=0, valid=0; out=0, out_valid=0 on the following cycle. Reset mid-stream discards all in-flight entries.
- flush=1 (reset=0): every stage valid=0; data registers keep their current values. flush overrides stall. Inputs presented in the flush cycle are dropped.
- stall=1 (reset=0, flush=0): all stages hold data and valid; inputs presented that cycle are dropped. out is stable for the whole stall.
- Normal advance: all stages shift by one every cycle.
- Data registers load regardless of in_valid. Downstream logic must qualify out with out_valid.
- stall and in_valid together: input is not captured and no error is raised. The upstream stage is responsible for re-presenting it.
- Simultaneous stall and flush: flush wins and the pipeline empties.
- Elaboration check: if 2^SELW < N or STAGES is outside 1..4, emit $error/$fatal at elaboration.

Optional Feature:
- Macro: MUX_SEL_CHECK_EN.
- Defined:
  - sel_err is a registered flag, asserted in the cycle after an edge that captured in_valid=1 with select >= N.
  - It is not pipelined with the data; it has 1-cycle latency regardless of STAGES.
  - It clears on the next non-erroring capture edge.
  - reset clears it; flush does not. stall holds it.
  - Simulation also prints a $display warning with the time and select value.
- Undefined: the sel_err port does not exist; out-of-range select silently produces 0.

Test Plan:
- W=32, N=4, STAGES=1; in_bus = {0xDDDD0003, 0xCCCC0002, 0xBBBB0001, 0xAAAA0000}, select=2, in_valid=1 -> next cycle out=0xCCCC0002, out_valid=1.
- Same config, N=3, SELW=2, select=3, in_valid=1 -> out=0x00000000, out_valid=1. With MUX_SEL_CHECK_EN, sel_err=1 for one cycle.
- STAGES=3; issue select=0,1,2,3 on cycles 0..3 with in_valid=1 -> out=0xAAAA0000, 0xBBBB0001, 0xCCCC0002, 0xDDDD0003 on cycles 3..6.
- STAGES=3; stall=1 on cycles 2..3 while streaming -> out and out_valid frozen for 2 cycles; the inputs offered on cycles 2..3 never appear; the remaining sequence resumes in order.
- STAGES=2 with 2 valid entries in flight; flush=1 together with stall=1 -> out_valid=0 on the next 2 cycles; out data unchanged.
- reset=1 asserted for one cycle mid-stream -> next cycle out=0, out_valid=0, sel_err=0; the first capture after reset appears after STAGES cycles.
